// File: rtl/ieee_to_int.sv
// IEEE-754 single-precision to signed 32-bit integer converter, round toward zero.
// Iterative shifter moves STEP bits per cycle (legal STEP: 1, 2, 4, 8).
`timescale 1ns/1ps
module ieee_to_int #(
    parameter int STEP = 1
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inputA,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] outputC,
    output logic        overflow,
    output logic        invalid
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [4:0] STEP_AMT = 5'(STEP);

    state_t      stateReg, stateNext;
    logic [31:0] magReg, magNext;
    logic [4:0]  remReg, remNext;
    logic        leftReg, leftNext;
    logic        signReg, signNext;
    logic        ovfPendReg, ovfPendNext;
    logic        invPendReg, invPendNext;
    logic        inReadyReg, inReadyNext;
    logic        outValidReg, outValidNext;
    logic [31:0] outputCReg, outputCNext;
    logic        overflowReg, overflowNext;
    logic        invalidReg, invalidNext;

    logic        accept;
    logic        signA;
    logic [7:0]  expA;
    logic [22:0] fracA;
    logic [4:0]  amt;
    logic [31:0] magShifted;
    logic        lastStep;

    assign accept = in_valid && inReadyReg;
    assign signA  = inputA[31];
    assign expA   = inputA[30:23];
    assign fracA  = inputA[22:0];

    assign amt        = (remReg < STEP_AMT) ? remReg : STEP_AMT;
    assign magShifted = leftReg ? (magReg << amt) : (magReg >> amt);
    assign lastStep   = (remReg == amt);

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            stateReg    <= IDLE;
            magReg      <= '0;
            remReg      <= '0;
            leftReg     <= 1'b0;
            signReg     <= 1'b0;
            ovfPendReg  <= 1'b0;
            invPendReg  <= 1'b0;
            inReadyReg  <= 1'b1;
            outValidReg <= 1'b0;
            outputCReg  <= '0;
            overflowReg <= 1'b0;
            invalidReg  <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            magReg      <= magNext;
            remReg      <= remNext;
            leftReg     <= leftNext;
            signReg     <= signNext;
            ovfPendReg  <= ovfPendNext;
            invPendReg  <= invPendNext;
            inReadyReg  <= inReadyNext;
            outValidReg <= outValidNext;
            outputCReg  <= outputCNext;
            overflowReg <= overflowNext;
            invalidReg  <= invalidNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (accept) stateNext = SHIFT;
            SHIFT:   if (lastStep) stateNext = DONE;
            DONE:    if (out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Special operands also pass through SHIFT with a zero count, so every result
    // arrives at least one edge after accept and uses the same output-load path.
    always_comb begin
        magNext      = magReg;
        remNext      = remReg;
        leftNext     = leftReg;
        signNext     = signReg;
        ovfPendNext  = ovfPendReg;
        invPendNext  = invPendReg;
        outputCNext  = outputCReg;
        overflowNext = overflowReg;
        invalidNext  = invalidReg;
        inReadyNext  = (stateNext == IDLE);
        outValidNext = (stateNext == DONE);
        case (stateReg)
            IDLE: begin
                if (accept) begin
                    signNext    = signA;
                    remNext     = '0;
                    leftNext    = 1'b0;
                    ovfPendNext = 1'b0;
                    invPendNext = 1'b0;
                    magNext     = '0;
                    if (expA == 8'd255) begin
                        if (fracA != 23'd0) begin
                            invPendNext = 1'b1;
                        end else begin
                            ovfPendNext = 1'b1;
                            magNext     = signA ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        end
                    end else if (expA >= 8'd158) begin
                        // Negating 0x80000000 yields itself, giving the negative saturation value.
                        magNext     = signA ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        ovfPendNext = (inputA != 32'hCF00_0000);
                    end else if (expA >= 8'd127) begin
                        magNext = {8'b0, 1'b1, fracA};
                        if (expA >= 8'd150) begin
                            leftNext = 1'b1;
                            remNext  = 5'(expA - 8'd150);
                        end else begin
                            remNext  = 5'(8'd150 - expA);
                        end
                    end
                end
            end
            SHIFT: begin
                magNext = magShifted;
                remNext = remReg - amt;
                if (lastStep) begin
                    outputCNext  = signReg ? -magShifted : magShifted;
                    overflowNext = ovfPendReg;
                    invalidNext  = invPendReg;
                end
            end
            DONE: begin
                if (out_ready) begin
                    overflowNext = 1'b0;
                    invalidNext  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign in_ready  = inReadyReg;
    assign out_valid = outValidReg;
    assign outputC   = outputCReg;
    assign overflow  = overflowReg;
    assign invalid   = invalidReg;

endmodule

// File: tb/tb_ieee_to_int.sv
// Scoreboard bench for ieee_to_int: one DUT per STEP value (1, 2, 4, 8), each with its
// own driver and monitor, checked against a real-arithmetic truncation model.
`timescale 1ns/1ps
module tb_ieee_to_int;

    typedef struct {
        logic [31:0] a;
        logic [31:0] c;
        logic        ovf;
        logic        inv;
        int          lat;
        int          acc;
        int          hold;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compareCount = 0;
    int failCount    = 0;
    int doneCount    = 0;

    task automatic check(input string name, input int step,
                         input logic [31:0] act, input logic [31:0] expv);
        compareCount++;
        if (act !== expv) begin
            failCount++;
            $display("FAIL S%0d %s: got %h expected %h", step, name, act, expv);
        end
    endtask

    task automatic failNow(input string name, input int step);
        compareCount++;
        failCount++;
        $display("FAIL S%0d %s", step, name);
    endtask

    // Reference: value = 1.f * 2^(e-127) in real arithmetic, truncated toward zero.
    function automatic exp_t model(input logic [31:0] a, input int step);
        exp_t r;
        int   ei;
        int   dd;
        int   iv;
        real  m;
        r.a = a; r.c = '0; r.ovf = 1'b0; r.inv = 1'b0; r.lat = 1; r.acc = 0; r.hold = 0;
        ei = int'(a[30:23]);
        if (ei == 255) begin
            if (a[22:0] != 23'd0) r.inv = 1'b1;
            else begin
                r.ovf = 1'b1;
                r.c   = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
            return r;
        end
        m = 1.0 + real'(a[22:0]) / 8388608.0;
        for (int i = 127; i < ei; i++) m = m * 2.0;
        for (int i = ei; i < 127; i++) m = m / 2.0;
        if (m >= 2147483648.0) begin
            if (a[31] && m == 2147483648.0) r.c = 32'h8000_0000;
            else begin
                r.ovf = 1'b1;
                r.c   = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
        end else begin
            iv  = $rtoi(m);
            r.c = a[31] ? 32'(-iv) : 32'(iv);
        end
        if (ei >= 127 && ei < 158) begin
            dd    = (ei >= 150) ? ei - 150 : 150 - ei;
            r.lat = (dd == 0) ? 1 : (dd + step - 1) / step;
        end
        return r;
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_step
        localparam int STEP = 1 << gi;

        logic        rst      = 1'b1;
        logic        inValid  = 1'b0;
        logic        outReady = 1'b0;
        logic [31:0] inputA   = '0;
        logic        inReady;
        logic        outValid;
        logic [31:0] outputC;
        logic        overflow;
        logic        invalid;
        exp_t        q[$];

        ieee_to_int #(.STEP(STEP)) dut (
            .clock_in (clk),
            .reset_in (rst),
            .in_valid (inValid),
            .in_ready (inReady),
            .inputA   (inputA),
            .out_valid(outValid),
            .out_ready(outReady),
            .outputC  (outputC),
            .overflow (overflow),
            .invalid  (invalid)
        );

        // Called at a negedge; returns at the negedge after the accepting edge.
        task automatic issue(input logic [31:0] a, input int hold, input bit push);
            exp_t e;
            int   n;
            n = 0;
            while (!inReady && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!inReady) begin
                failNow("in_ready_timeout", STEP);
                return;
            end
            e      = model(a, STEP);
            e.acc  = cyc + 1;
            e.hold = hold;
            inputA  = a;
            inValid = 1'b1;
            if (push) q.push_back(e);
            @(negedge clk);
            inValid = 1'b0;
            inputA  = $urandom();
        endtask

        initial begin : driver
            logic [31:0] dirA[12];
            int          dirHold[12];
            logic [31:0] a;
            logic [7:0]  ex;
            int          n;
            int          rcyc;
            dirA = '{32'h3F00_0000, 32'h4F00_0000, 32'hCF00_0000, 32'hFF80_0000,
                     32'h7FC0_0000, 32'h4100_0000, 32'h8000_0000, 32'hBF00_0000,
                     32'h7F80_0000, 32'h4EFF_FFFF, 32'hCEFF_FFFF, 32'h0000_0001};
            dirHold = '{0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0};

            repeat (3) @(negedge clk);
            check("reset_in_ready",  STEP, 32'(inReady),  32'd1);
            check("reset_out_valid", STEP, 32'(outValid), 32'd0);
            check("reset_outputC",   STEP, outputC,       32'd0);
            check("reset_flags",     STEP, {30'd0, overflow, invalid}, 32'd0);
            rst = 1'b0;
            @(negedge clk);

            issue(32'h3F80_0000, 0, 1'b1);
            issue(32'h40F0_0000, 10, 1'b1);
            issue(32'hC080_0000, 0, 1'b1);

            // Asynchronous reset in the middle of a shift of 1.0.
            issue(32'h3F80_0000, 0, 1'b0);
            rcyc = (STEP == 1) ? 5 : 1;
            repeat (rcyc - 1) @(posedge clk);
            #2 rst = 1'b1;
            #1;
            check("async_rst_in_ready",  STEP, 32'(inReady),  32'd1);
            check("async_rst_out_valid", STEP, 32'(outValid), 32'd0);
            check("async_rst_outputC",   STEP, outputC,       32'd0);
            check("async_rst_flags",     STEP, {30'd0, overflow, invalid}, 32'd0);
            @(negedge clk);
            rst = 1'b0;
            repeat (30) @(negedge clk);
            check("no_partial_result", STEP, 32'(outValid), 32'd0);
            issue(32'h4040_0000, 0, 1'b1);

            for (int i = 0; i < 12; i++) issue(dirA[i], dirHold[i], 1'b1);

            for (int i = 0; i < 1000; i++) begin
                if ($urandom_range(0, 9) < 7) ex = 8'($urandom_range(120, 160));
                else                          ex = 8'($urandom_range(0, 254));
                a = {1'($urandom), ex, 23'($urandom)};
                if ($urandom_range(0, 49) == 0) a = 32'hCF00_0000;
                issue(a, $urandom_range(0, 2), 1'b1);
            end

            n = 0;
            while ((q.size() != 0 || outValid) && n < 2000) begin
                @(negedge clk);
                n++;
            end
            if (q.size() != 0) failNow("drain_timeout", STEP);
            doneCount++;
        end

        initial begin : monitor
            exp_t e;
            int   lat;
            forever begin
                @(negedge clk);
                if (!rst && outValid) begin
                    if (q.size() == 0) begin
                        failNow("unexpected_output", STEP);
                        outReady = 1'b1;
                        @(negedge clk);
                        outReady = 1'b0;
                    end else begin
                        e   = q.pop_front();
                        lat = cyc - e.acc;
                        $display("S%0d A=%h C=%h ovf=%b inv=%b lat=%0d", STEP, e.a,
                                 outputC, overflow, invalid, lat);
                        check("outputC",  STEP, outputC,       e.c);
                        check("overflow", STEP, 32'(overflow), 32'(e.ovf));
                        check("invalid",  STEP, 32'(invalid),  32'(e.inv));
                        check("latency",  STEP, 32'(lat),      32'(e.lat));
                        check("flags_exclusive", STEP, 32'(overflow & invalid), 32'd0);
                        for (int h = 0; h < e.hold; h++) begin
                            @(negedge clk);
                            check("hold_out_valid", STEP, 32'(outValid), 32'd1);
                            check("hold_outputC",   STEP, outputC,       e.c);
                            check("hold_in_ready",  STEP, 32'(inReady),  32'd0);
                        end
                        outReady = 1'b1;
                        @(negedge clk);
                        outReady = 1'b0;
                        check("drop_out_valid", STEP, 32'(outValid), 32'd0);
                        check("in_ready_back",  STEP, 32'(inReady),  32'd1);
                        check("flags_cleared",  STEP, {30'd0, overflow, invalid}, 32'd0);
                        check("outputC_kept",   STEP, outputC,       e.c);
                    end
                end
            end
        end
    end

    initial begin : finisher
        int n;
        n = 0;
        while (doneCount < 4 && n < 90000) begin
            @(posedge clk);
            n++;
        end
        if (doneCount < 4) failNow("global_timeout", 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
